// File: rtl/risc_datapath_if.sv
// Control-unit <-> execution-datapath bus: instruction issue, results, flags and debug read.
interface risc_datapath_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              start;
  logic              ready;
  logic [3:0]        opcode;
  logic [1:0]        src_sel;
  logic [ADDR_W-1:0] rs0;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rd0;
  logic [ADDR_W-1:0] rd1;
  logic              we0;
  logic              we1;
  logic [DATA_W-1:0] imm_val;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] result_0;
  logic [DATA_W-1:0] result_1;
  logic [3:0]        flags;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output start, opcode, src_sel, rs0, rs1, rd0, rd1, we0, we1, imm_val, data_in, dbg_addr,
    input  ready, result_0, result_1, flags, done, err, dbg_data
  );

  modport slave (
    input  start, opcode, src_sel, rs0, rs1, rd0, rd1, we0, we1, imm_val, data_in, dbg_addr,
    output ready, result_0, result_1, flags, done, err, dbg_data
  );
endinterface

// File: rtl/risc_datapath.sv
// Multi-cycle execution datapath: register file, dual-result ALU, writeback mux, start/done handshake.
module risc_datapath #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NREGS      = 8,
  parameter int unsigned MUL_CYCLES = 2,
  parameter bit          ZERO_R0    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  risc_datapath_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(NREGS);
  localparam int unsigned SH_W   = $clog2(DATA_W);
  localparam int unsigned PW     = 2 * DATA_W;
  localparam int unsigned CNT_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_PAS = 4'd9;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_DIN = 2'd1;
  localparam logic [1:0] SRC_RS0 = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_WB} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREGS];
  logic [3:0]        op_q;
  logic [1:0]        src_q;
  logic [ADDR_W-1:0] rs0_q, rs1_q, rd0_q, rd1_q;
  logic              we0_q, we1_q;
  logic [DATA_W-1:0] imm_q, din_q, op1_q, op2_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] result_0_q, result_1_q;
  logic [3:0]        flags_q;
  logic              done_q, err_q;

  logic [DATA_W-1:0] alu_lo, alu_hi, wb_val;
  logic              alu_c, alu_v, illegal;
  logic [DATA_W:0]   add_full, sub_full, shl_full, shr_full;
  logic [PW-1:0]     prod;
  logic [SH_W-1:0]   amt;

  // R0 reads as zero when hardwired
  function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 && (a == '0)) ? '0 : regs[a];
  endfunction

  // R0 writes are dropped when hardwired
  function automatic logic wr_ok(input logic [ADDR_W-1:0] a);
    return !(ZERO_R0 && (a == '0));
  endfunction

  assign bus.ready    = (state == S_IDLE);
  assign bus.result_0 = result_0_q;
  assign bus.result_1 = result_1_q;
  assign bus.flags    = flags_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.dbg_data = rd_reg(bus.dbg_addr);

  // ALU on latched operands plus writeback source selection
  always_comb begin
    amt      = op2_q[SH_W-1:0];
    add_full = {1'b0, op1_q} + {1'b0, op2_q};
    sub_full = {1'b0, op1_q} - {1'b0, op2_q};
    shl_full = {1'b0, op1_q} << amt;
    shr_full = {op1_q, 1'b0} >> amt;
    prod     = PW'(op1_q) * PW'(op2_q);
    alu_lo   = '0;
    alu_hi   = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    illegal  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_lo = add_full[DATA_W-1:0];
        alu_c  = add_full[DATA_W];
        alu_v  = (op1_q[DATA_W-1] == op2_q[DATA_W-1]) && (alu_lo[DATA_W-1] != op1_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_lo = sub_full[DATA_W-1:0];
        alu_c  = sub_full[DATA_W];
        alu_v  = (op1_q[DATA_W-1] != op2_q[DATA_W-1]) && (alu_lo[DATA_W-1] != op1_q[DATA_W-1]);
      end
      OP_AND: alu_lo = op1_q & op2_q;
      OP_OR:  alu_lo = op1_q | op2_q;
      OP_XOR: alu_lo = op1_q ^ op2_q;
      OP_NOT: alu_lo = ~op1_q;
      OP_SHL: begin
        alu_lo = shl_full[DATA_W-1:0];
        alu_c  = shl_full[DATA_W];
      end
      OP_SHR: begin
        alu_lo = shr_full[DATA_W:1];
        alu_c  = shr_full[0];
      end
      OP_MUL: begin
        alu_lo = prod[DATA_W-1:0];
        alu_hi = prod[PW-1:DATA_W];
        alu_c  = |alu_hi;
      end
      OP_PAS: alu_lo = op2_q;
      default: illegal = 1'b1;
    endcase
    case (src_q)
      SRC_ALU: wb_val = alu_lo;
      SRC_DIN: wb_val = din_q;
      SRC_RS0: wb_val = op1_q;
      default: wb_val = imm_q;
    endcase
  end

  // Control FSM, operand latches, register file and committed outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      src_q      <= '0;
      rs0_q      <= '0;
      rs1_q      <= '0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      we0_q      <= 1'b0;
      we1_q      <= 1'b0;
      imm_q      <= '0;
      din_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      cnt        <= '0;
      result_0_q <= '0;
      result_1_q <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q  <= bus.opcode;
            src_q <= bus.src_sel;
            rs0_q <= bus.rs0;
            rs1_q <= bus.rs1;
            rd0_q <= bus.rd0;
            rd1_q <= bus.rd1;
            we0_q <= bus.we0;
            we1_q <= bus.we1;
            imm_q <= bus.imm_val;
            state <= S_RD;
          end
        end
        S_RD: begin
          op1_q <= rd_reg(rs0_q);
          op2_q <= rd_reg(rs1_q);
          din_q <= bus.data_in;
          // Only an ALU-sourced MUL occupies EX for more than one cycle
          cnt   <= (op_q == OP_MUL && src_q == SRC_ALU) ? CNT_W'(MUL_CYCLES - 1) : '0;
          state <= S_EX;
        end
        S_EX: begin
          if (cnt == '0) state <= S_WB;
          else           cnt   <= cnt - 1'b1;
        end
        S_WB: begin
          state  <= S_IDLE;
          done_q <= 1'b1;
          err_q  <= illegal;
          if (!illegal) begin
            if (src_q == SRC_ALU) begin
              result_1_q <= alu_hi;
              flags_q    <= {alu_v, alu_c, alu_lo[DATA_W-1], (alu_lo == '0)};
              if (we1_q && op_q == OP_MUL && wr_ok(rd1_q)) regs[rd1_q] <= alu_hi;
            end
            // Port 0 is written last so it wins when rd0 == rd1
            if (we0_q && wr_ok(rd0_q)) regs[rd0_q] <= wb_val;
            result_0_q <= wb_val;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_risc_datapath.sv
// Randomised self-checking bench for risc_datapath against a behavioural instruction model.
module tb_risc_datapath;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;
  localparam int MC = 2;
  localparam bit ZR0 = 1'b1;
  localparam longint MASK = (64'd1 << DW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  int m_regs [NR];
  int m_res0, m_res1, m_flags;

  risc_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  risc_datapath #(.DATA_W(DW), .NREGS(NR), .MUL_CYCLES(MC), .ZERO_R0(ZR0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_rd(input int a);
    return (ZR0 && a == 0) ? 0 : m_regs[a];
  endfunction

  function automatic longint sgn(input longint x);
    return (x >= (64'd1 << (DW - 1))) ? x - (64'd1 << DW) : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    m_res0 = 0; m_res1 = 0; m_flags = 0;
  endtask

  // Architectural effect of one instruction; returns expected outputs after commit
  task automatic model_exec(input int op, input int src, input int a0, input int a1,
                            input int d0, input int d1, input int w0, input int w1,
                            input int imm, input int din, output int e_err);
    longint a, b, r, hi, p, ss;
    int c, v, amt, wb;
    a = longint'(m_rd(a0));
    b = longint'(m_rd(a1));
    e_err = (op >= 10) ? 1 : 0;
    if (e_err != 0) return;
    r = 0; hi = 0; c = 0; v = 0;
    amt = int'(b % DW);
    case (op)
      0: begin r = a + b; c = (r > MASK) ? 1 : 0; ss = sgn(a) + sgn(b); end
      1: begin r = a - b; c = (a < b) ? 1 : 0; ss = sgn(a) - sgn(b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = a << amt; c = (amt != 0) ? int'((a >> (DW - amt)) & 1) : 0; end
      7: begin r = a >> amt; c = (amt != 0) ? int'((a >> (amt - 1)) & 1) : 0; end
      8: begin p = a * b; r = p; hi = p >> DW; c = (hi != 0) ? 1 : 0; end
      default: r = b;
    endcase
    if (op <= 1) v = (ss > (64'sd1 << (DW - 1)) - 1 || ss < -(64'sd1 << (DW - 1))) ? 1 : 0;
    r = r & MASK;
    case (src)
      0: wb = int'(r);
      1: wb = din;
      2: wb = int'(a);
      default: wb = imm;
    endcase
    if (src == 0) begin
      m_res1  = int'(hi);
      m_flags = (v << 3) | (c << 2) | (int'(r >> (DW - 1)) << 1) | ((r == 0) ? 1 : 0);
      if (op == 8 && w1 != 0 && !(ZR0 && d1 == 0)) m_regs[d1] = int'(hi);
    end
    if (w0 != 0 && !(ZR0 && d0 == 0)) m_regs[d0] = wb;
    m_res0 = wb;
  endtask

  task automatic drive(input int op, input int src, input int a0, input int a1, input int d0,
                       input int d1, input int w0, input int w1, input int imm, input int din);
    bus.opcode  = 4'(op);
    bus.src_sel = 2'(src);
    bus.rs0     = AW'(a0);
    bus.rs1     = AW'(a1);
    bus.rd0     = AW'(d0);
    bus.rd1     = AW'(d1);
    bus.we0     = 1'(w0);
    bus.we1     = 1'(w1);
    bus.imm_val = DW'(imm);
    bus.data_in = DW'(din);
  endtask

  task automatic check_outputs(input int e_err, input int dbg);
    chk("err", 32'(bus.err), 32'(e_err));
    chk("result_0", 32'(bus.result_0), 32'(m_res0));
    chk("result_1", 32'(bus.result_1), 32'(m_res1));
    chk("flags", 32'(bus.flags), 32'(m_flags));
    chk("dbg_reg", 32'(bus.dbg_data), 32'(m_rd(dbg)));
  endtask

  // Issue one instruction (back-to-back if the previous one just finished) and check its commit
  task automatic run_instr(input int op, input int src, input int a0, input int a1, input int d0,
                           input int d1, input int w0, input int w1, input int imm, input int din);
    int e_err, lat, dbg;
    bit seen;
    dbg = int'($urandom_range(0, NR - 1));
    chk("ready", 32'(bus.ready), 32'd1);
    drive(op, src, a0, a1, d0, d1, w0, w1, imm, din);
    bus.dbg_addr = AW'(dbg);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    model_exec(op, src, a0, a1, d0, d1, w0, w1, imm, din, e_err);
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin seen = 1'b1; lat = i; end
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    // Latency counted in edges, the accept edge included
    chk("latency", 32'(lat + 1), (op == 8 && src == 0) ? 32'(3 + MC) : 32'd4);
    check_outputs(e_err, dbg);
  endtask

  task automatic rd_dbg(input int a, output int v);
    bus.dbg_addr = AW'(a);
    #1;
    v = int'(bus.dbg_data);
  endtask

  task automatic check_regs();
    int v;
    for (int i = 0; i < NR; i++) begin
      rd_dbg(i, v);
      chk("regfile", 32'(v), 32'(m_rd(i)));
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done), 32'd0);
  endtask

  function automatic int rnd_data();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return int'(MASK);
      2: return 32'h7FFF;
      3: return 32'h8000;
      default: return int'($urandom_range(0, 32'hFFFF));
    endcase
  endfunction

  initial begin
    int v, ndone, e_err;
    bus.start = 1'b0;
    bus.dbg_addr = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    check_outputs(0, 1);
    check_regs();

    // Immediate load
    run_instr(0, 3, 0, 0, 1, 0, 1, 0, 32'h1234, 0);
    idle_cycle();
    rd_dbg(1, v);
    chk("t1_r1", 32'(v), 32'h1234);
    chk("t1_flags", 32'(bus.flags), 32'd0);

    // ADD overflow, SUB borrow
    run_instr(0, 3, 0, 0, 1, 0, 1, 0, 32'h7FFF, 0);
    run_instr(0, 3, 0, 0, 2, 0, 1, 0, 32'h0001, 0);
    run_instr(0, 0, 1, 2, 3, 0, 1, 0, 0, 0);
    idle_cycle();
    rd_dbg(3, v);
    chk("t2_add", 32'(v), 32'h8000);
    chk("t2_add_flags", 32'(bus.flags), 32'b1010);
    run_instr(1, 0, 2, 1, 6, 0, 1, 0, 0, 0);
    chk("t2_sub_flags", 32'(bus.flags), 32'b0110);

    // MUL with both write ports
    run_instr(0, 3, 0, 0, 1, 0, 1, 0, 32'h1234, 0);
    run_instr(0, 3, 0, 0, 2, 0, 1, 0, 32'h0100, 0);
    run_instr(8, 0, 1, 2, 4, 5, 1, 1, 0, 0);
    chk("t3_flags", 32'(bus.flags), 32'b0100);
    idle_cycle();
    rd_dbg(4, v);
    chk("t3_lo", 32'(v), 32'h3400);
    rd_dbg(5, v);
    chk("t3_hi", 32'(v), 32'h0012);

    // Illegal opcode, R0 write, data_in and rs0 sources
    run_instr(12, 0, 1, 2, 3, 4, 1, 1, 0, 0);
    chk("t4_err", 32'(bus.err), 32'd1);
    run_instr(0, 3, 0, 0, 0, 0, 1, 0, 32'hBEEF, 0);
    chk("t4_res0", 32'(bus.result_0), 32'hBEEF);
    run_instr(3, 1, 0, 0, 7, 0, 1, 0, 0, 32'hA5A5);
    run_instr(3, 2, 1, 0, 6, 0, 1, 0, 0, 0);
    idle_cycle();
    check_regs();

    // start during EX is ignored
    drive(0, 0, 1, 2, 7, 0, 1, 0, 0, 0);
    bus.start = 1'b1;
    model_exec(0, 0, 1, 2, 7, 0, 1, 0, 0, 0, e_err);
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    drive(9, 0, 0, 1, 6, 0, 1, 0, 0, 0);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    chk("t5_done", 32'(bus.done), 32'd1);
    check_outputs(e_err, 7);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("t5_extra_done", 32'(ndone), 32'd0);
    check_regs();

    // reset in EX: no done, no write
    drive(0, 3, 0, 0, 3, 0, 1, 0, 32'h5555, 0);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("t5_rst_done", 32'(ndone), 32'd0);
    chk("t5_rst_ready", 32'(bus.ready), 32'd1);
    check_outputs(0, 3);
    check_regs();

    // Random program
    for (int i = 1; i < NR; i++) run_instr(0, 3, 0, 0, i, 0, 1, 0, rnd_data(), 0);
    for (int n = 0; n < 300; n++) begin
      int op, src;
      op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      src = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      run_instr(op, src, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), rnd_data(), rnd_data());
      if (n % 25 == 24) begin
        idle_cycle();
        check_regs();
      end
    end
    idle_cycle();
    check_regs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
